// File: rtl/obi_arb_pkg.sv
// Shared types for the two-master OBI data-port arbiter and its outstanding-ID FIFO.
package obi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HOLD_M0,
    ARB_HOLD_M1
  } arb_state_e;

  typedef logic master_id_t;

  localparam master_id_t M0_ID = 1'b0;
  localparam master_id_t M1_ID = 1'b1;

endpackage

// File: rtl/obi_id_fifo.sv
// Small FIFO of requester IDs for transactions awaiting rvalid.
// A push into a full FIFO is accepted only when a pop frees the head in the same cycle.
module obi_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] id_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = ptr_inc(wr_q);
    if (do_pop)  rd_d = ptr_inc(rd_q);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= id_i;
  end

  cnt_in_range_a: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= FULL_CNT);

endmodule

// File: rtl/obi_data_arbiter.sv
// Shares one OBI RAM data port between the core (m0) and the debug system-bus master (m1),
// routing each rvalid back to its issuer via an outstanding-ID FIFO.
module obi_data_arbiter
  import obi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int FIXED_PRIO      = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e state_q, state_d;
  master_id_t rr_q, rr_d;
  logic       err_q, err_d;

  master_id_t sel_id;
  logic       sel_req;
  logic       can_issue;
  logic       accept;
  master_id_t fifo_head;
  logic       fifo_empty;
  logic       fifo_full;
  logic [CW-1:0] fifo_cnt;

  // Winner selection; a HOLD state pins the choice until the address phase is granted.
  always_comb begin
    sel_id  = M0_ID;
    sel_req = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        sel_req = m0_req_i | m1_req_i;
        if (m0_req_i && m1_req_i) sel_id = (FIXED_PRIO != 0) ? M1_ID : rr_q;
        else if (m1_req_i)        sel_id = M1_ID;
      end
      ARB_HOLD_M0: sel_req = m0_req_i;
      ARB_HOLD_M1: begin
        sel_id  = M1_ID;
        sel_req = m1_req_i;
      end
      default: ;
    endcase
  end

  // A same-cycle response pop frees a slot for a new issue.
  assign can_issue = ~fifo_full | s_rvalid_i;
  assign s_req_o   = sel_req & can_issue;
  assign accept    = s_req_o & s_gnt_i;

  assign s_addr_o  = (sel_id == M1_ID) ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = (sel_id == M1_ID) ? m1_we_i    : m0_we_i;
  assign s_be_o    = (sel_id == M1_ID) ? m1_be_i    : m0_be_i;
  assign s_wdata_o = (sel_id == M1_ID) ? m1_wdata_i : m0_wdata_i;

  assign m0_gnt_o = accept & (sel_id == M0_ID);
  assign m1_gnt_o = accept & (sel_id == M1_ID);

  assign m0_rvalid_o = s_rvalid_i & ~fifo_empty & (fifo_head == M0_ID);
  assign m1_rvalid_o = s_rvalid_i & ~fifo_empty & (fifo_head == M1_ID);
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  assign busy_o = (fifo_cnt != '0);
  assign err_o  = err_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    err_d   = err_q | (s_rvalid_i & fifo_empty);
    if (accept) rr_d = ~sel_id;
    unique case (state_q)
      ARB_IDLE: begin
        if (s_req_o && !s_gnt_i) state_d = (sel_id == M1_ID) ? ARB_HOLD_M1 : ARB_HOLD_M0;
      end
      ARB_HOLD_M0, ARB_HOLD_M1: begin
        if (!sel_req || accept) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      rr_q    <= M0_ID;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .pop_i   (s_rvalid_i),
    .id_i    (sel_id),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Directed bench driving a round-robin and a fixed-priority arbiter from the same stimulus.
module tb_obi_data_arbiter
  import obi_arb_pkg::*;
;

  logic        clk_i, rst_i;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        s_gnt, s_rvalid;
  logic [31:0] s_rdata;

  logic        rr_m0_gnt, rr_m0_rvalid, rr_m1_gnt, rr_m1_rvalid, rr_s_req, rr_s_we, rr_busy, rr_err;
  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata;
  logic [3:0]  rr_s_be;
  logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid, fp_s_req, fp_s_we, fp_busy, fp_err;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic [3:0]  fp_s_be;

  int nchk;
  int nerr;

  obi_data_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .FIXED_PRIO(0)) u_rr (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(rr_m0_gnt), .m0_rvalid_o(rr_m0_rvalid), .m0_rdata_o(rr_m0_rdata),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(rr_m1_gnt), .m1_rvalid_o(rr_m1_rvalid), .m1_rdata_o(rr_m1_rdata),
    .s_req_o(rr_s_req), .s_addr_o(rr_s_addr), .s_we_o(rr_s_we), .s_be_o(rr_s_be), .s_wdata_o(rr_s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .busy_o(rr_busy), .err_o(rr_err)
  );

  obi_data_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .FIXED_PRIO(1)) u_fp (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(fp_m0_gnt), .m0_rvalid_o(fp_m0_rvalid), .m0_rdata_o(fp_m0_rdata),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(fp_m1_gnt), .m1_rvalid_o(fp_m1_rvalid), .m1_rdata_o(fp_m1_rdata),
    .s_req_o(fp_s_req), .s_addr_o(fp_s_addr), .s_we_o(fp_s_we), .s_be_o(fp_s_be), .s_wdata_o(fp_s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .busy_o(fp_busy), .err_o(fp_err)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_be = 4'hF; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_be = 4'hF; m1_wdata = 0;
    s_gnt = 0; s_rvalid = 0;
  endtask

  task automatic do_reset();
    tick();
    rst_i = 1;
    idle_inputs();
    tick();
    rst_i = 0;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rst_i = 1;
    idle_inputs();
    s_rdata = 0;
    tick();
    tick();
    rst_i = 0;
    s_rdata = 32'h1234_5678;
    #4;
    chk("rst_s_req", rr_s_req, 0);
    chk("rst_m0_gnt", rr_m0_gnt, 0);
    chk("rst_m1_gnt", rr_m1_gnt, 0);
    chk("rst_m0_rvalid", rr_m0_rvalid, 0);
    chk("rst_m1_rvalid", rr_m1_rvalid, 0);
    chk("rst_busy", rr_busy, 0);
    chk("rst_err", rr_err, 0);
    chk("rst_m0_rdata", rr_m0_rdata, 32'h1234_5678);
    chk("rst_m1_rdata", rr_m1_rdata, 32'h1234_5678);
    chk("rst_state", 32'(u_rr.state_q), 32'(ARB_IDLE));
    chk("rst_fp_s_req", fp_s_req, 0);

    // Single m0 read, one-cycle response.
    tick(); m0_req = 1; m0_addr = 32'h100; s_gnt = 1; #4;
    chk("t1_m0_gnt", rr_m0_gnt, 1);
    chk("t1_m1_gnt", rr_m1_gnt, 0);
    chk("t1_s_addr", rr_s_addr, 32'h100);
    chk("t1_busy_c0", rr_busy, 0);
    chk("t1_fp_m0_gnt", fp_m0_gnt, 1);
    tick(); m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; #4;
    chk("t1_m0_rvalid", rr_m0_rvalid, 1);
    chk("t1_m0_rdata", rr_m0_rdata, 32'hDEAD_BEEF);
    chk("t1_m1_rvalid", rr_m1_rvalid, 0);
    chk("t1_busy_c1", rr_busy, 1);
    tick(); s_rvalid = 0; #4;
    chk("t1_busy_c2", rr_busy, 0);
    chk("t1_m0_rvalid_off", rr_m0_rvalid, 0);

    // Round-robin alternation with pipelined responses.
    do_reset();
    tick();
    m0_req = 1; m0_addr = 32'h200;
    m1_req = 1; m1_addr = 32'h300; m1_we = 1; m1_be = 4'h3; m1_wdata = 32'hCAFE;
    s_gnt = 1; #4;
    chk("t2_c1_m0_gnt", rr_m0_gnt, 1);
    chk("t2_c1_m1_gnt", rr_m1_gnt, 0);
    chk("t2_c1_s_addr", rr_s_addr, 32'h200);
    chk("t2_c1_s_we", rr_s_we, 0);
    tick(); s_rvalid = 1; s_rdata = 32'hA0; #4;
    chk("t2_c2_m1_gnt", rr_m1_gnt, 1);
    chk("t2_c2_m0_gnt", rr_m0_gnt, 0);
    chk("t2_c2_s_addr", rr_s_addr, 32'h300);
    chk("t2_c2_s_we", rr_s_we, 1);
    chk("t2_c2_s_be", rr_s_be, 4'h3);
    chk("t2_c2_s_wdata", rr_s_wdata, 32'hCAFE);
    chk("t2_c2_m0_rvalid", rr_m0_rvalid, 1);
    chk("t2_c2_m1_rvalid", rr_m1_rvalid, 0);
    chk("t2_c2_m0_rdata", rr_m0_rdata, 32'hA0);
    tick(); s_rdata = 32'hA1; #4;
    chk("t2_c3_m0_gnt", rr_m0_gnt, 1);
    chk("t2_c3_m1_rvalid", rr_m1_rvalid, 1);
    chk("t2_c3_m0_rvalid", rr_m0_rvalid, 0);
    tick(); s_rdata = 32'hA2; #4;
    chk("t2_c4_m1_gnt", rr_m1_gnt, 1);
    chk("t2_c4_m0_rvalid", rr_m0_rvalid, 1);
    tick(); m0_req = 0; m1_req = 0; s_rdata = 32'hA3; #4;
    chk("t2_c5_m1_rvalid", rr_m1_rvalid, 1);
    chk("t2_c5_m0_rvalid", rr_m0_rvalid, 0);
    chk("t2_c5_s_req", rr_s_req, 0);
    tick(); s_rvalid = 0; #4;
    chk("t2_busy", rr_busy, 0);
    chk("t2_err", rr_err, 0);
    chk("t2_fp_err", fp_err, 0);

    // Fixed priority: m1 held through three ungranted cycles.
    do_reset();
    tick(); m1_req = 1; m1_addr = 32'h400; m0_req = 1; m0_addr = 32'h500; s_gnt = 0; #4;
    chk("t3_c1_s_addr", fp_s_addr, 32'h400);
    chk("t3_c1_s_req", fp_s_req, 1);
    chk("t3_c1_m1_gnt", fp_m1_gnt, 0);
    chk("t3_c1_m0_gnt", fp_m0_gnt, 0);
    chk("t3_c1_rr_s_addr", rr_s_addr, 32'h500);
    tick(); #4;
    chk("t3_c2_s_addr", fp_s_addr, 32'h400);
    chk("t3_c2_state", 32'(u_fp.state_q), 32'(ARB_HOLD_M1));
    chk("t3_c2_m1_gnt", fp_m1_gnt, 0);
    tick(); #4;
    chk("t3_c3_s_addr", fp_s_addr, 32'h400);
    chk("t3_c3_m1_gnt", fp_m1_gnt, 0);
    tick(); s_gnt = 1; #4;
    chk("t3_c4_m1_gnt", fp_m1_gnt, 1);
    chk("t3_c4_m0_gnt", fp_m0_gnt, 0);
    chk("t3_c4_s_addr", fp_s_addr, 32'h400);
    tick(); m1_req = 0; #4;
    chk("t3_c5_m0_gnt", fp_m0_gnt, 1);
    chk("t3_c5_s_addr", fp_s_addr, 32'h500);
    tick(); m0_req = 0; s_gnt = 0; #4;
    chk("t3_busy", fp_busy, 1);
    chk("t3_s_req", fp_s_req, 0);

    // Outstanding limit and same-cycle pop/push while full.
    do_reset();
    tick(); m0_req = 1; m0_addr = 32'h600; s_gnt = 1; #4;
    chk("t4_c1_m0_gnt", rr_m0_gnt, 1);
    tick(); #4;
    chk("t4_c2_m0_gnt", rr_m0_gnt, 1);
    tick(); #4;
    chk("t4_c3_s_req", rr_s_req, 0);
    chk("t4_c3_m0_gnt", rr_m0_gnt, 0);
    chk("t4_c3_busy", rr_busy, 1);
    tick(); s_rvalid = 1; s_rdata = 32'h77; #4;
    chk("t4_c4_s_req", rr_s_req, 1);
    chk("t4_c4_m0_gnt", rr_m0_gnt, 1);
    chk("t4_c4_m0_rvalid", rr_m0_rvalid, 1);
    chk("t4_c4_m0_rdata", rr_m0_rdata, 32'h77);
    tick(); m0_req = 0; s_rvalid = 0; #4;
    chk("t4_count", 32'(u_rr.fifo_cnt), 2);
    chk("t4_err", rr_err, 0);

    // Unexpected response sets sticky error.
    do_reset();
    tick(); s_rvalid = 1; s_rdata = 32'h55; #4;
    chk("t5_m0_rvalid", rr_m0_rvalid, 0);
    chk("t5_m1_rvalid", rr_m1_rvalid, 0);
    chk("t5_err_c0", rr_err, 0);
    tick(); s_rvalid = 0; #4;
    chk("t5_err_c1", rr_err, 1);
    tick(); tick(); #4;
    chk("t5_err_sticky", rr_err, 1);

    // Reset with two outstanding clears count and rr pointer.
    do_reset();
    tick(); m0_req = 1; m0_addr = 32'h700; s_gnt = 1; #4;
    chk("t6_c1_m0_gnt", rr_m0_gnt, 1);
    tick(); #4;
    chk("t6_c2_m0_gnt", rr_m0_gnt, 1);
    tick(); m0_req = 0; rst_i = 1; #4;
    chk("t6_busy_pre", rr_busy, 1);
    tick(); rst_i = 0; #4;
    chk("t6_busy_post", rr_busy, 0);
    chk("t6_state", 32'(u_rr.state_q), 32'(ARB_IDLE));
    chk("t6_err", rr_err, 0);
    tick(); m0_req = 1; m0_addr = 32'h800; m1_req = 1; m1_addr = 32'h900; #4;
    chk("t6_m0_gnt", rr_m0_gnt, 1);
    chk("t6_m1_gnt", rr_m1_gnt, 0);
    chk("t6_s_addr", rr_s_addr, 32'h800);
    tick(); idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/obi_data_arbiter.md
Name: obi_data_arbiter

Overview:
Two-requester arbiter sharing the single RAM data port between the core data interface (m0) and the debug-module system-bus master (m1). It uses the same req/gnt/rvalid protocol on all sides.
It tracks outstanding transactions in an ID FIFO so each rvalid/rdata returns to the requester that issued it.
It sits between cv32e40p_core/dm_top and mm_ram, replacing the separate sb_* port on the memory.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; be width is DATA_WIDTH/8
MAX_OUTSTANDING, 2, depth of the outstanding-ID FIFO (>=1)
FIXED_PRIO, 0, 0 = round-robin; 1 = m1 (debug) always wins

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
m0_req_i  in  1  core request
m0_addr_i  in  ADDR_WIDTH  core address
m0_we_i  in  1  core write enable
m0_be_i  in  DATA_WIDTH/8  core byte enables
m0_wdata_i  in  DATA_WIDTH  core write data
m0_gnt_o  out  1  core grant
m0_rvalid_o  out  1  core response valid
m0_rdata_o  out  DATA_WIDTH  core read data
m1_*  same set as m0_*  debug system-bus master
s_req_o  out  1  memory request
s_addr_o  out  ADDR_WIDTH  memory address
s_we_o  out  1  memory write enable
s_be_o  out  DATA_WIDTH/8  memory byte enables
s_wdata_o  out  DATA_WIDTH  memory write data
s_gnt_i  in  1  memory grant
s_rvalid_i  in  1  memory response valid
s_rdata_i  in  DATA_WIDTH  memory read data
busy_o  out  1  outstanding count != 0
err_o  out  1  sticky: rvalid arrived with FIFO empty

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - FIFO empty, count 0, rr pointer = m0, state ARB_IDLE, err_o 0.
  - Combinational outputs are then 0: s_req_o, all gnt_o, all rvalid_o, busy_o.
  - rdata_o outputs carry s_rdata_i unqualified.
- Request path is zero-latency combinational.
  - s_* mirrors the selected master.
  - sel_gnt_o = s_gnt_i & s_req_o. The unselected master's gnt_o is 0.
- can_issue = (count < MAX_OUTSTANDING) | s_rvalid_i (a pop frees a slot the same cycle). While can_issue is 0, s_req_o = 0.
- FSM states:
  - ARB_IDLE: pick the winner among the requesting masters.
    - FIXED_PRIO=1: m1 wins.
    - FIXED_PRIO=0: the rr pointer master wins on conflict.
    - If the winner is granted in the same cycle, stay in ARB_IDLE.
    - If not granted, go to ARB_HOLD_M0 or ARB_HOLD_M1.
  - ARB_HOLD_Mx: selection locked to x, because the address phase must stay stable until gnt. The other master is never selected here.
    - On the grant, return to ARB_IDLE.
    - If x drops req (protocol violation), return to ARB_IDLE with no FIFO push.
- Round-robin: on each accepted transaction (s_req_o & s_gnt_i), the rr pointer moves to the other master.
- FIFO:
  - Push the winner ID on each accepted transaction.
  - Pop on s_rvalid_i.
  - Push and pop in the same cycle is legal, including when full; count is unchanged.
  - Wrap-around uses modulo-MAX_OUTSTANDING pointers.
- Response path is combinational: mx_rvalid_o = s_rvalid_i & !empty & (head == x).
- Unexpected response: s_rvalid_i while empty sets err_o (sticky until reset) and is forwarded to no master.
- Writes also occupy a FIFO slot, since the memory returns rvalid for writes.
- Reset mid-transaction discards all outstanding IDs. Memory and arbiter must be reset together, otherwise err_o flags the late responses.
- All counters are sized $clog2(MAX_OUTSTANDING+1). A count beyond MAX_OUTSTANDING is unreachable; add an assertion for it.

Decomposition:
- Package obi_arb_pkg:
  - typedef arb_state_e {ARB_IDLE, ARB_HOLD_M0, ARB_HOLD_M1}
  - typedef master_id_t (1 bit)
  - localparams M0_ID = 0, M1_ID = 1
- Sub-module obi_id_fifo: parameterised DEPTH/width FIFO.
  - Ports: push, pop, id_i, head_o, empty_o, full_o, count_o.
  - Same-cycle push/pop when full.
  - Synchronous active-high reset.

Test Plan:
- Single m0 read, s_gnt_i tied 1, rvalid 1 cycle later with rdata 0xDEADBEEF: m0_gnt_o in cycle 0, m0_rvalid_o with 0xDEADBEEF in cycle 1, m1_rvalid_o stays 0, busy_o 1 for exactly 1 cycle.
- FIXED_PRIO=0, m0 and m1 requesting continuously, gnt always 1: accepted IDs alternate 0,1,0,1; responses routed in issue order.
- m1 requests with s_gnt_i low for 3 cycles while m0 also asserts req (FIXED_PRIO=1): s_addr_o stays at m1's address all 3 cycles; m1_gnt_o on the 4th cycle; m0 served next.
- MAX_OUTSTANDING=2, two accepted reads with no rvalid: third request sees s_req_o 0. Assert s_rvalid_i: the third request is issued in the same cycle and count stays 2.
- s_rvalid_i pulse after reset with no request: err_o rises next cycle and stays 1; no mx_rvalid_o.
- rst_i asserted with 2 outstanding: next cycle busy_o 0, state ARB_IDLE, next request from m0 wins (rr pointer reset).
